// File: rtl/iq_accumulator_if.sv
// Handshake/data bundle between the IQ rotator, the accumulator and the
// downstream binning/classifier stage. The accumulator takes the slave side.
interface iq_accumulator_if #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 11
);
  logic                      start;
  logic [LEN_W-1:0]          sample_length;
  logic [LANES-1:0]          lane_valid;
  logic [LANES*DATA_W-1:0]   data_i_rot;
  logic [LANES*DATA_W-1:0]   data_q_rot;
  logic                      iq_ready;
  logic                      iq_valid;
  logic signed [ACC_W-1:0]   i_val;
  logic signed [ACC_W-1:0]   q_val;
  logic                      overflow;
  logic                      busy;
  logic                      start_err;

  modport master (
    output start, sample_length, lane_valid, data_i_rot, data_q_rot, iq_ready,
    input  iq_valid, i_val, q_val, overflow, busy, start_err
  );

  modport slave (
    input  start, sample_length, lane_valid, data_i_rot, data_q_rot, iq_ready,
    output iq_valid, i_val, q_val, overflow, busy, start_err
  );
endinterface

// File: rtl/iq_accumulator.sv
// Multi-lane saturating I/Q integrator. Each clock adds the masked sum of
// LANES rotated samples into wide signed accumulators for sample_length
// groups, then holds the result on a valid/ready handshake.
module iq_accumulator #(
  parameter int LANES  = 5,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 11
) (
  input  logic         clk_100,
  input  logic         reset,
  iq_accumulator_if.slave bus
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, INTEGRATE, HOLD} state_t;

  state_t                   state;
  logic [LEN_W-1:0]         len_r;
  logic [LEN_W-1:0]         count_r;
  logic signed [ACC_W-1:0]  acc_i_p1;
  logic signed [ACC_W-1:0]  acc_q_p1;
  logic                     vld_p1;
  logic                     ovf_r;
  logic                     busy_r;
  logic                     start_err_r;

  logic signed [ACC_W-1:0]  grp_i_p0;
  logic signed [ACC_W-1:0]  grp_q_p0;
  logic signed [ACC_W:0]    sum_i_p0;
  logic signed [ACC_W:0]    sum_q_p0;
  logic [LEN_W-1:0]         count_nxt;

  // Sign-extend one lane sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] s);
    return {{(ACC_W-DATA_W){s[DATA_W-1]}}, s};
  endfunction

  // One guard bit wider than the accumulator so the carry out is visible.
  function automatic logic signed [ACC_W:0] add_wide(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
    return {a[ACC_W-1], a} + {b[ACC_W-1], b};
  endfunction

  // Out of range whenever the guard bit disagrees with the accumulator sign bit.
  function automatic logic is_clipped(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
    if (is_clipped(s)) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // Stage p0: masked full-precision group sum and wide running sum.
  always_comb begin
    grp_i_p0 = '0;
    grp_q_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      if (bus.lane_valid[k]) begin
        grp_i_p0 = grp_i_p0 + sext(bus.data_i_rot[k*DATA_W +: DATA_W]);
        grp_q_p0 = grp_q_p0 + sext(bus.data_q_rot[k*DATA_W +: DATA_W]);
      end
    end
    sum_i_p0  = add_wide(acc_i_p1, grp_i_p0);
    sum_q_p0  = add_wide(acc_q_p1, grp_q_p0);
    count_nxt = count_r + LEN_W'(1);
  end

  // Stage p1: run control FSM with registered accumulators and status outputs.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state       <= IDLE;
      len_r       <= '0;
      count_r     <= '0;
      acc_i_p1    <= '0;
      acc_q_p1    <= '0;
      vld_p1      <= 1'b0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      start_err_r <= 1'b0;
    end else begin
      start_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_r  <= bus.sample_length;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            if (bus.sample_length == '0) begin
              // Zero-length run: start-cycle data is ignored, result is 0.
              acc_i_p1 <= '0;
              acc_q_p1 <= '0;
              count_r  <= '0;
              vld_p1   <= 1'b1;
              state    <= HOLD;
            end else begin
              // A single group cannot saturate given the ACC_W sizing rule.
              acc_i_p1 <= grp_i_p0;
              acc_q_p1 <= grp_q_p0;
              count_r  <= LEN_W'(1);
              if (bus.sample_length == LEN_W'(1)) begin
                vld_p1 <= 1'b1;
                state  <= HOLD;
              end else begin
                state  <= INTEGRATE;
              end
            end
          end
        end
        INTEGRATE: begin
          if (bus.start) start_err_r <= 1'b1;
          acc_i_p1 <= saturate(sum_i_p0);
          acc_q_p1 <= saturate(sum_q_p0);
          if (is_clipped(sum_i_p0) || is_clipped(sum_q_p0)) ovf_r <= 1'b1;
          count_r <= count_nxt;
          if (count_nxt == len_r) begin
            vld_p1 <= 1'b1;
            state  <= HOLD;
          end
        end
        HOLD: begin
          // A start on the handshake cycle is still a busy-time start.
          if (bus.start) start_err_r <= 1'b1;
          if (bus.iq_ready) begin
            vld_p1  <= 1'b0;
            busy_r  <= 1'b0;
            count_r <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.iq_valid  = vld_p1;
  assign bus.i_val     = acc_i_p1;
  assign bus.q_val     = acc_q_p1;
  assign bus.overflow  = ovf_r;
  assign bus.busy      = busy_r;
  assign bus.start_err = start_err_r;

endmodule

// File: tb/tb_iq_accumulator.sv
// Directed bench for iq_accumulator: a 32-bit accumulator instance for the
// general runs and a 20-bit instance sharing the same stimulus for saturation.
module tb_iq_accumulator;
  localparam int LANES  = 5;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 11;

  logic clk_100 = 1'b0;
  logic reset;
  logic                    start;
  logic [LEN_W-1:0]        sample_length;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*DATA_W-1:0] data_i_rot;
  logic [LANES*DATA_W-1:0] data_q_rot;
  logic                    iq_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk_100 = ~clk_100;

  iq_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .LEN_W(LEN_W)) bus32 ();
  iq_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(20), .LEN_W(LEN_W)) bus20 ();

  assign bus32.start = start;         assign bus20.start = start;
  assign bus32.sample_length = sample_length; assign bus20.sample_length = sample_length;
  assign bus32.lane_valid = lane_valid;       assign bus20.lane_valid = lane_valid;
  assign bus32.data_i_rot = data_i_rot;       assign bus20.data_i_rot = data_i_rot;
  assign bus32.data_q_rot = data_q_rot;       assign bus20.data_q_rot = data_q_rot;
  assign bus32.iq_ready = iq_ready;           assign bus20.iq_ready = iq_ready;

  iq_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .LEN_W(LEN_W)) dut (
    .clk_100 (clk_100),
    .reset   (reset),
    .bus     (bus32)
  );

  iq_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(20), .LEN_W(LEN_W)) dut20 (
    .clk_100 (clk_100),
    .reset   (reset),
    .bus     (bus20)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic set_all(input int i, input int q);
    for (int k = 0; k < LANES; k++) begin
      data_i_rot[k*DATA_W +: DATA_W] = DATA_W'(i);
      data_q_rot[k*DATA_W +: DATA_W] = DATA_W'(q);
    end
  endtask

  task automatic do_start(input int len);
    sample_length = LEN_W'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    sample_length = LEN_W'(1999);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    sample_length = '0;
    lane_valid = '1;
    data_i_rot = '0;
    data_q_rot = '0;
    iq_ready = 1'b1;
    step();
    step();
    check("rst_valid", bus32.iq_valid, 0);
    check("rst_busy", bus32.busy, 0);
    check("rst_ival", bus32.i_val, 0);
    check("rst_ovf", bus32.overflow, 0);
    check("rst_serr", bus32.start_err, 0);
    reset = 1'b0;
    step();

    // L=4, all lanes, I=+100, Q=-50
    set_all(100, -50);
    do_start(4);
    check("t1_busy_t1", bus32.busy, 1);
    check("t1_run_i_t1", bus32.i_val, 500);
    check("t1_valid_t1", bus32.iq_valid, 0);
    step(); step();
    check("t1_valid_t3", bus32.iq_valid, 0);
    step();
    check("t1_valid_t4", bus32.iq_valid, 1);
    check("t1_i", bus32.i_val, 2000);
    check("t1_q", bus32.q_val, -1000);
    check("t1_ovf", bus32.overflow, 0);
    step();
    check("t1_valid_t5", bus32.iq_valid, 0);
    check("t1_busy_t5", bus32.busy, 0);

    // L=3, mask 10101, I lanes 1..5
    lane_valid = 5'b10101;
    for (int k = 0; k < LANES; k++) begin
      data_i_rot[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
      data_q_rot[k*DATA_W +: DATA_W] = DATA_W'(-(k + 1));
    end
    do_start(3);
    step();
    check("t2_valid_t2", bus32.iq_valid, 0);
    step();
    check("t2_valid_t3", bus32.iq_valid, 1);
    check("t2_i", bus32.i_val, 27);
    check("t2_q", bus32.q_val, -27);
    step();
    lane_valid = '1;

    // Saturation on the 20-bit instance, L=40, I=32767
    set_all(32767, 0);
    do_start(40);
    for (int n = 1; n < 40; n++) step();
    check("t3_valid", bus20.iq_valid, 1);
    check("t3_i20", bus20.i_val, 524287);
    check("t3_ovf20", bus20.overflow, 1);
    check("t3_i32", bus32.i_val, 6553400);
    check("t3_ovf32", bus32.overflow, 0);
    step();
    set_all(1, 0);
    do_start(1);
    check("t3b_valid", bus20.iq_valid, 1);
    check("t3b_i20", bus20.i_val, 5);
    check("t3b_ovf20", bus20.overflow, 0);
    step();

    // L=2 held by iq_ready=0; start during hold is rejected
    set_all(7, -3);
    iq_ready = 1'b0;
    do_start(2);
    step();
    check("t4_valid", bus32.iq_valid, 1);
    check("t4_i", bus32.i_val, 70);
    check("t4_q", bus32.q_val, -30);
    set_all(1000, 1000);
    do_start(5);
    check("t4_serr", bus32.start_err, 1);
    check("t4_i_after_serr", bus32.i_val, 70);
    for (int n = 0; n < 4; n++) step();
    check("t4_serr_clr", bus32.start_err, 0);
    check("t4_valid_hold", bus32.iq_valid, 1);
    check("t4_i_hold", bus32.i_val, 70);
    check("t4_q_hold", bus32.q_val, -30);
    iq_ready = 1'b1;
    step();
    check("t4_valid_drop", bus32.iq_valid, 0);

    // L=0: immediate zero result; start on handshake cycle is rejected
    set_all(9, 9);
    do_start(0);
    check("t5_valid", bus32.iq_valid, 1);
    check("t5_i", bus32.i_val, 0);
    check("t5_q", bus32.q_val, 0);
    do_start(3);
    check("t5_serr", bus32.start_err, 1);
    check("t5_valid_drop", bus32.iq_valid, 0);
    step();
    check("t5_idle_busy", bus32.busy, 0);

    // Reset mid-run, then a fresh run
    set_all(1, 1);
    do_start(10);
    for (int n = 1; n < 5; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid", bus32.iq_valid, 0);
    check("t6_rst_i", bus32.i_val, 0);
    check("t6_rst_busy", bus32.busy, 0);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bus32.iq_valid) seen++;
    end
    check("t6_no_result", seen, 0);
    set_all(3, 4);
    do_start(2);
    step();
    check("t6_valid", bus32.iq_valid, 1);
    check("t6_i", bus32.i_val, 30);
    check("t6_q", bus32.q_val, 40);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iq_accumulator.md
# iq_accumulator

Parametrised successor to the single-shot IQ integrator. Accumulates rotated I/Q samples from LANES parallel lanes per clock over a programmable number of sample groups. Per-lane valid masking, saturating wide accumulators and a sticky overflow flag are included. The result is presented on a valid/ready handshake to the binning/classifier stage. It sits between the multiplier (rotated IQ) and the analysis stage, started by the timing block's start pulse.

## Interface
Parameters:
- LANES, 5: samples delivered per clock.
- DATA_W, 16: signed width of each rotated I/Q sample.
- ACC_W, 32: signed accumulator/output width; must be ≥ DATA_W + clog2(LANES) + 1.
- LEN_W, 11: width of sample_length (groups of LANES samples).

Ports:
- clk_100  in  1  clock; reset reset, synchronous, active-high; clock clk_100.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; first sample group is present on this cycle.
- sample_length  in  LEN_W  number of groups to integrate; sampled on accepted start.
- lane_valid  in  LANES  bit k set: lane k contributes this cycle.
- data_i_rot  in  LANES*DATA_W  signed, lane k at bits [k*DATA_W +: DATA_W].
- data_q_rot  in  LANES*DATA_W  signed, same packing.
- iq_ready  in  1  downstream accepts result.
- iq_valid  out  1  result held and valid.
- i_val  out  ACC_W  signed I sum.
- q_val  out  ACC_W  signed Q sum.
- overflow  out  1  sticky per run; the run's accumulator saturated.
- busy  out  1  high in INTEGRATE and HOLD.
- start_err  out  1  one-cycle pulse when start arrives while busy.

## Operation
- States: IDLE, INTEGRATE, HOLD. All outputs are registered.
- Reset (any state, any time): state IDLE, counter 0, i_val/q_val 0, iq_valid 0, overflow 0, busy 0, start_err 0. A run in progress is discarded and no result is produced.
- IDLE + start:
  - Latch sample_length into len_r.
  - If len_r ≥ 1: load the accumulators with this cycle's masked group sum, clear overflow, set counter=1, go to INTEGRATE.
  - If len_r == 0: clear the accumulators and overflow, go directly to HOLD.
- INTEGRATE: each cycle, while counter < len_r, add the group sum and increment counter.
  - When counter == len_r, the just-completed accumulators stand and the block enters HOLD.
  - sample_length changes after start have no effect.
- Group sum: each lane is sign-extended to ACC_W and zeroed where lane_valid[k]=0. The lanes are added with full-precision combinational adds. No wrap is possible inside the group sum, given the ACC_W rule.
- Accumulate: acc + group_sum is saturating. Results are clamped to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and overflow is set; overflow remains set until the next accepted start or reset.
- HOLD: iq_valid=1 with i_val/q_val stable. On iq_valid && iq_ready: iq_valid 0, go to IDLE next cycle. A start on that same cycle is rejected (start_err).
- start while busy: ignored; start_err pulses the next cycle. The current run is unaffected.
- lane_valid all zero in a group: the group still counts toward len_r and contributes 0.

## Timing
- Accepted start at cycle t, L = len_r ≥ 1: groups on cycles t..t+L-1 are accumulated. iq_valid rises at t+L, together with the final i_val/q_val.
- L = 0: iq_valid at t+1, i_val=q_val=0, and the start-cycle data is ignored.
- Latency is start to result L cycles (min 1), plus handshake stall.
- busy rises at t+1 and falls on the cycle after the accepting handshake.
- Earliest next start is accepted the cycle after iq_valid falls, so back-to-back throughput is L+1 cycles per run with iq_ready held high.
- i_val/q_val update every INTEGRATE cycle (running sum visible). They are valid only while iq_valid=1.
- overflow is valid with iq_valid.

## Test plan
- LANES=5, L=4, all lanes valid, I=+100, Q=-50 per sample, iq_ready=1 -> iq_valid at t+4 for 1 cycle, i_val=2000, q_val=-1000, overflow 0.
- L=3, lane_valid=5'b10101, I lanes=1,2,3,4,5 constant -> i_val=3*(1+3+5)=27; cycle-exact with iq_valid at t+3.
- ACC_W=20, L=40, all I=32767 -> i_val=524287, overflow=1. The next run of L=1 with I=1 gives i_val=5, overflow=0.
- L=2, iq_ready=0 for 6 cycles -> iq_valid and values held constant. A start during the hold gives a start_err pulse and unchanged results. When iq_ready goes to 1, iq_valid drops the next cycle.
- L=0 start -> iq_valid at t+1, i_val=q_val=0. A reset asserted mid-run (L=10, at t+5) -> all outputs 0 next cycle, no iq_valid; a new start afterwards produces a correct fresh result.
